inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Packs decoded RV32I fields plus a 32-bit immediate into a 32-bit instruction word.
//  This is the inverse of the core's immediate extraction, covering all opcode classes in define.vh,
//  including the Mtype matrix load/store.
//  Feeds the instruction-memory loader and the self-check bench from a valid/ready stream.
//  Registered output and a one-entry skid buffer give full throughput under backpressure.
//  Flags any immediate that cannot be represented in its format, and counts those errors.
// PARAMETERS
//  ERR_CNT_W  16  width of saturating error counter
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rstn       in   1   asynchronous active-low reset
//  in_valid   in   1   field bundle valid
//  in_ready   out  1   encoder can accept bundle this cycle
//  opcode     in   7   inst[6:0], matched against define.vh opcode macros
//  rd         in   5   destination register
//  rs1        in   5   source register 1
//  rs2        in   5   source register 2
//  funct3     in   3   funct3 field
//  funct7     in   7   funct7 field (R-type only)
//  imm        in   32  full immediate, byte offset for B/J, un-shifted value for U
//  out_valid  out  1   encoded word valid
//  out_ready  in   1   consumer accepts word
//  out_inst   out  32  encoded instruction
//  out_err    out  1   immediate out of range or unknown opcode, travels with out_inst
//  err_cnt    out  ERR_CNT_W  saturating count of transferred words with out_err=1
// BEHAVIOUR
//  Reset (rstn=0, async): out_valid=0, out_inst=0, out_err=0, err_cnt=0, skid empty, in_ready=1.
//  Reset mid-operation drops every in-flight word.
//  Transfer rules:
//   - Input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
//   - Latency 1 cycle: a bundle accepted at edge N appears on out_inst after edge N (empty pipe).
//   - in_ready = !skid_valid, a register output with no combinational path from out_ready.
//   - Output reg empty or draining: accepted word loads output reg; else it loads the skid entry.
//   - Output transfer with skid full: skid moves to output reg and in_ready rises next cycle.
//   - Strict FIFO order. out_inst/out_err stay stable while out_valid&!out_ready.
//  Encoding, rd/rs1/rs2/funct3/opcode placed at standard RV32I bit positions for each format:
//   - ItypeL/ItypeA/ItypeJ, Mtype with funct3=M_LD: inst[31:20]=imm[11:0].
//   - Stype, Mtype with funct3=M_ST: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
//   - Btype: {imm[12],imm[10:5]} -> [31:25]; {imm[4:1],imm[11]} -> [11:7].
//   - Jtype: {imm[20],imm[10:1],imm[11],imm[19:12]} -> [31:12].
//   - UtypeL/UtypeU: inst[31:12]=imm[31:12].
//   - R-type (0110011): funct7 into [31:25], imm ignored.
//   - Mtype with other funct3: immediate bits 0.
//  Range checks (err=1 if violated; word still emitted with truncated fields):
//   - I/S/M: imm[31:11] all equal.
//   - B: imm[31:12] all equal and imm[0]=0.
//   - J: imm[31:20] all equal and imm[0]=0.
//   - U: imm[11:0]=0.
//  Unknown opcode: err=1, immediate/funct7 bits 0, other fields placed as R-type.
//  err_cnt increments on each output transfer with out_err=1 and saturates at all-ones.
// TESTING
//  - addi: op=0010011 rd=1 rs1=0 f3=0 imm=5 -> out_inst=0x00500093, err=0, 1-cycle latency.
//  - sw: op=0100011 rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423.
//  - beq: op=1100011 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
//  - jal: op=1101111 rd=1 imm=0x800 -> 0x001000EF.
//  - lui: op=0110111 rd=0 imm=0x12345001 -> 0x12345037, err=1, err_cnt 0->1.
//    addi imm=4096 -> err=1, err_cnt=2.
//  - Backpressure: stream 6 back-to-back bundles, out_ready=0 for 3 cycles.
//    Required: in_ready=0 after 2 accepts, no loss/dup, order kept.
//    Then a rstn pulse mid-stream -> out_valid=0 and err_cnt=0 immediately.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction packer: decoded fields plus a 32-bit immediate in, one encoded word out.
// A registered output stage with a one-entry skid buffer sustains one word per cycle under backpressure.
module inst_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Opcode classes (define.vh values); Mtype is the custom-0 matrix load/store slot.
  localparam logic [6:0] OP_ITYPE_L = 7'b0000011;
  localparam logic [6:0] OP_ITYPE_A = 7'b0010011;
  localparam logic [6:0] OP_ITYPE_J = 7'b1100111;
  localparam logic [6:0] OP_STYPE   = 7'b0100011;
  localparam logic [6:0] OP_BTYPE   = 7'b1100011;
  localparam logic [6:0] OP_JTYPE   = 7'b1101111;
  localparam logic [6:0] OP_UTYPE_L = 7'b0110111;
  localparam logic [6:0] OP_UTYPE_U = 7'b0010111;
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_MTYPE   = 7'b0001011;

  localparam logic [2:0] M_LD = 3'b000;
  localparam logic [2:0] M_ST = 3'b001;

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // A producer holds valid and its payload unchanged until that transfer; ready never
  // depends combinationally on valid. in_ready is a pure register (!skid_valid).

  logic        skid_valid;
  logic [31:0] skid_inst;
  logic        skid_err;

  logic        in_fire;
  logic        out_fire;

  logic [31:0] enc_inst;
  logic        enc_err;

  // Representability: the bits above the field's sign bit must all replicate it.
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;
  logic        u_aligned;

  assign fits_12   = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_13   = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_21   = (&imm[31:20]) | ~(|imm[31:20]);
  assign u_aligned = ~(|imm[11:0]);

  logic [31:0] word_i;
  logic [31:0] word_s;
  logic [31:0] word_b;
  logic [31:0] word_j;
  logic [31:0] word_u;
  logic [31:0] word_r;
  logic [31:0] word_r0;

  assign word_i  = {imm[11:0], rs1, funct3, rd, opcode};
  assign word_s  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
  assign word_b  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  assign word_j  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
  assign word_u  = {imm[31:12], rd, opcode};
  assign word_r  = {funct7, rs2, rs1, funct3, rd, opcode};
  assign word_r0 = {7'b0000000, rs2, rs1, funct3, rd, opcode};

  always_comb begin
    enc_inst = word_r0;
    enc_err  = 1'b0;
    case (opcode)
      OP_ITYPE_L, OP_ITYPE_A, OP_ITYPE_J: begin
        enc_inst = word_i;
        enc_err  = ~fits_12;
      end
      OP_STYPE: begin
        enc_inst = word_s;
        enc_err  = ~fits_12;
      end
      OP_BTYPE: begin
        enc_inst = word_b;
        enc_err  = ~fits_13 | imm[0];
      end
      OP_JTYPE: begin
        enc_inst = word_j;
        enc_err  = ~fits_21 | imm[0];
      end
      OP_UTYPE_L, OP_UTYPE_U: begin
        enc_inst = word_u;
        enc_err  = ~u_aligned;
      end
      OP_RTYPE: begin
        enc_inst = word_r;
        enc_err  = 1'b0;
      end
      OP_MTYPE: begin
        // Matrix ops without an immediate keep the R layout with a zero funct7 slot.
        case (funct3)
          M_LD: begin
            enc_inst = word_i;
            enc_err  = ~fits_12;
          end
          M_ST: begin
            enc_inst = word_s;
            enc_err  = ~fits_12;
          end
          default: begin
            enc_inst = word_r0;
            enc_err  = 1'b0;
          end
        endcase
      end
      default: begin
        enc_inst = word_r0;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // skid_valid implies out_valid: the skid only fills while the output register is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_inst   <= 32'h0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_inst  <= 32'h0;
      skid_err   <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_inst   <= skid_inst;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_inst  <= enc_inst;
        out_err   <= enc_err;
      end else begin
        skid_valid <= 1'b1;
        skid_inst  <= enc_inst;
        skid_err   <= enc_err;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (out_fire && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed known encodings, backpressure and reset steps, then a
// randomized stream scored against an arithmetic reference encoder.
module tb_inst_encoder;

  localparam int CW = 4;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_ALUI  = 7'b0010011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_M     = 7'b0001011;
  localparam logic [2:0] F3_MLD    = 3'b000;
  localparam logic [2:0] F3_MST    = 3'b001;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [31:0]   imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [CW-1:0] err_cnt;

  inst_encoder #(.ERR_CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard state: {err, inst} per accepted bundle
  logic [32:0]   exp_q[$];
  logic [CW-1:0] exp_cnt = '0;
  logic          hold_pend = 1'b0;
  logic [32:0]   hold_val = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: fields placed by arithmetic weights, ranges checked as signed integers.
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] im);
    int unsigned u, w, o, dd, a1, a2, ff3, ff7, regs_r, top;
    int si;
    bit e;
    u = im; si = $signed(im);
    o = op; dd = d; a1 = s1; a2 = s2; ff3 = f3; ff7 = f7;
    top = 32'h8000_0000;
    regs_r = a2 * 1048576 + a1 * 32768 + ff3 * 4096 + dd * 128 + o;
    w = regs_r; e = 1'b1;
    if (op == OPC_LOAD || op == OPC_ALUI || op == OPC_JALR || (op == OPC_M && f3 == F3_MLD)) begin
      w = (u % 4096) * 1048576 + a1 * 32768 + ff3 * 4096 + dd * 128 + o;
      e = (si < -2048) || (si > 2047);
    end else if (op == OPC_STORE || (op == OPC_M && f3 == F3_MST)) begin
      w = ((u / 32) % 128) * 33554432 + a2 * 1048576 + a1 * 32768 + ff3 * 4096 + (u % 32) * 128 + o;
      e = (si < -2048) || (si > 2047);
    end else if (op == OPC_BR) begin
      w = ((u / 4096) % 2) * top + ((u / 32) % 64) * 33554432 + a2 * 1048576 + a1 * 32768
          + ff3 * 4096 + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + o;
      e = (si < -4096) || (si > 4095) || (u % 2 != 0);
    end else if (op == OPC_JAL) begin
      w = ((u / 1048576) % 2) * top + ((u / 2) % 1024) * 2097152 + ((u / 2048) % 2) * 1048576
          + ((u / 4096) % 256) * 4096 + dd * 128 + o;
      e = (si < -1048576) || (si > 1048575) || (u % 2 != 0);
    end else if (op == OPC_LUI || op == OPC_AUIPC) begin
      w = u - (u % 4096) + dd * 128 + o;
      e = (u % 4096) != 0;
    end else if (op == OPC_R) begin
      w = ff7 * 33554432 + regs_r;
      e = 1'b0;
    end else if (op == OPC_M) begin
      w = regs_r;
      e = 1'b0;
    end
    return {e, w[31:0]};
  endfunction

  // scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      exp_cnt = '0;
      hold_pend = 1'b0;
    end else begin
      logic [32:0] e;
      check("err_cnt", err_cnt, exp_cnt);
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_err, out_inst}, hold_val);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_word", {out_err, out_inst}, e);
          if (e[32] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val = {out_err, out_inst};
      if (in_valid && in_ready)
        exp_q.push_back(ref_encode(opcode, rd, rs1, rs2, funct3, funct7, imm));
    end
  end

  // driver tasks
  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: r = $urandom;
      1: r = $urandom_range(0, 8191) - 32'd4096;
      2: r = ($urandom_range(0, 1) != 0 ? 32'h0010_0000 : 32'hFFF0_0000) + $urandom_range(0, 4095) - 32'd2048;
      3: r = $urandom & 32'hFFFF_F000;
      default: r = $urandom_range(0, 4095) - 32'd2048;
    endcase
    return r;
  endfunction

  task automatic rand_fields();
    logic [6:0] ops [11];
    ops = '{OPC_LOAD, OPC_ALUI, OPC_JALR, OPC_STORE, OPC_BR, OPC_JAL,
            OPC_LUI, OPC_AUIPC, OPC_R, OPC_M, 7'b1111111};
    opcode = ops[$urandom_range(0, 10)];
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    imm = rand_imm();
  endtask

  task automatic drive_accept();
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_timeout", t < 200, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_check(input string tag, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im,
                            input logic [31:0] exp_inst, input logic exp_e, input logic [CW-1:0] exp_c);
    @(posedge clk); #1;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_pre_valid"}, out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_err"}, out_err, exp_e);
    @(posedge clk); #1;
    check({tag, "_cnt"}, err_cnt, exp_c);
    check({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int t;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rstn = 1'b1;

    // directed encodings
    send_check("addi", OPC_ALUI, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0093, 1'b0, 4'd0);
    send_check("sw", OPC_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0, 4'd0);
    send_check("beq", OPC_BR, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0, 4'd0);
    send_check("jal", OPC_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0, 4'd0);
    send_check("lui", OPC_LUI, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001, 32'h1234_5037, 1'b1, 4'd1);
    send_check("addi_big", OPC_ALUI, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096, 32'h0000_0093, 1'b1, 4'd2);
    send_check("sub", OPC_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0, 4'd2);
    send_check("unknown", 7'h7F, 5'd1, 5'd2, 5'd3, 3'b001, 7'h7F, 32'h0000_0123, 32'h0031_10FF, 1'b1, 4'd3);

    // backpressure: two accepts fill output and skid, then stall three cycles
    out_ready = 1'b0;
    rand_fields(); in_valid = 1'b1; drive_accept();
    rand_fields(); in_valid = 1'b1; drive_accept();
    check("bp_in_ready_low", in_ready, 0);
    rand_fields(); in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    drive_accept();
    for (int k = 0; k < 3; k++) begin
      rand_fields(); in_valid = 1'b1; drive_accept();
    end
    repeat (4) @(posedge clk);
    #1;
    check("bp_all_delivered", exp_q.size(), 0);
    check("bp_idle", out_valid, 0);

    // reset pulse mid-stream
    out_ready = 1'b0;
    opcode = 7'h7F; in_valid = 1'b1; drive_accept();
    rand_fields(); in_valid = 1'b1; drive_accept();
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_err", out_err, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // randomized stream with random backpressure
    acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          rand_fields(); in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("final_drain", t < 50, 1);
    check("final_queue_empty", exp_q.size(), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
